// File: rtl/mem_responder.sv
// Word-organised RAM behind a req/busy/done handshake with a fixed number of wait states.
// Supports byte-lane writes and reports out-of-range addresses on completion.
module mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byte_en,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [1:0]  state_dbg
);

  // Handshake: a request is taken on any rising edge where req=1 and busy=0.
  // busy stays high from that edge until the done cycle ends; done pulses for one
  // cycle with err and (for reads) rdata valid in that same cycle.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
  localparam int         DEPTH    = 2 ** ADDR_W;

  state_t      state;
  logic [3:0]  cnt;
  logic        cap_wr;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_be;

  logic [31:0] mem [DEPTH];

  logic              acc_wr;
  logic [31:0]       acc_addr;
  logic [31:0]       acc_wdata;
  logic [3:0]        acc_be;
  logic [ADDR_W-1:0] acc_idx;
  logic              acc_oor;
  logic              enter_done;
  logic              unused_addr_lsbs;

  // With zero latency the access happens on the acceptance edge itself, before
  // the request has landed in the capture registers, so take it from the inputs.
  always_comb begin
    acc_wr    = cap_wr;
    acc_addr  = cap_addr;
    acc_wdata = cap_wdata;
    acc_be    = cap_be;
    if (state == IDLE) begin
      acc_wr    = wr;
      acc_addr  = addr;
      acc_wdata = wdata;
      acc_be    = byte_en;
    end
  end

  assign acc_idx          = acc_addr[ADDR_W+1:2];
  assign acc_oor          = |acc_addr[31:ADDR_W+2];
  assign unused_addr_lsbs = ^{acc_addr[1:0], addr[1:0], cap_addr[1:0]};

  always_comb begin
    enter_done = 1'b0;
    if (!reset) begin
      case (state)
        IDLE:    enter_done = req && (LATENCY == 0);
        WAIT:    enter_done = (cnt == 4'd0);
        default: enter_done = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      cnt       <= '0;
      cap_wr    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            cap_wr    <= wr;
            cap_addr  <= addr;
            cap_wdata <= wdata;
            cap_be    <= byte_en;
            cnt       <= CNT_INIT;
            busy      <= 1'b1;
            state     <= (LATENCY == 0) ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
      if (enter_done) begin
        done <= 1'b1;
        err  <= acc_oor;
        if (!acc_wr) begin
          rdata <= acc_oor ? 32'd0 : mem[acc_idx];
        end
      end
    end
  end

  // RAM is deliberately left out of reset; only enabled lanes of in-range writes land.
  always_ff @(posedge clock) begin
    if (enter_done && acc_wr && !acc_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) begin
          mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (LATENCY=2 and LATENCY=0) checked every cycle
// against a transaction-level model, plus directed literal expectations.
module tb_mem_responder;

  localparam int AW = 8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic             reset;
  logic [1:0]       req, wr;
  logic [1:0][31:0] addr, wdata;
  logic [1:0][3:0]  byte_en;
  logic [1:0]       busy, done, err;
  logic [1:0][31:0] rdata;
  logic [1:0][1:0]  state_dbg;

  mem_responder #(.ADDR_W(AW), .LATENCY(2)) dut_l2 (
    .clock(clock), .reset(reset), .req(req[0]), .wr(wr[0]), .addr(addr[0]),
    .wdata(wdata[0]), .byte_en(byte_en[0]), .busy(busy[0]), .done(done[0]),
    .err(err[0]), .rdata(rdata[0]), .state_dbg(state_dbg[0])
  );

  mem_responder #(.ADDR_W(AW), .LATENCY(0)) dut_l0 (
    .clock(clock), .reset(reset), .req(req[1]), .wr(wr[1]), .addr(addr[1]),
    .wdata(wdata[1]), .byte_en(byte_en[1]), .busy(busy[1]), .done(done[1]),
    .err(err[1]), .rdata(rdata[1]), .state_dbg(state_dbg[1])
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // Each transaction occupies LATENCY+1 busy cycles after acceptance; the last of
  // them is the done cycle, and the RAM is touched as that cycle begins.
  logic        started = 1'b0;
  int          left [2];
  logic        m_wr [2];
  logic [31:0] m_addr [2], m_wdata [2];
  logic [3:0]  m_be [2];
  logic [31:0] m_mem [2][256];
  logic        e_busy [2], e_done [2], e_err [2];
  logic [31:0] e_rdata [2];

  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      int   lat_k;
      logic oor;
      int   idx;
      lat_k = (k == 0) ? 2 : 0;
      if (reset) begin
        left[k]    = 0;
        e_rdata[k] = 32'd0;
      end else if (left[k] == 0) begin
        if (req[k]) begin
          m_wr[k]    = wr[k];
          m_addr[k]  = addr[k];
          m_wdata[k] = wdata[k];
          m_be[k]    = byte_en[k];
          left[k]    = lat_k + 1;
        end
      end else begin
        left[k] = left[k] - 1;
      end
      e_busy[k] = (left[k] > 0);
      e_done[k] = (left[k] == 1);
      e_err[k]  = 1'b0;
      if (e_done[k]) begin
        oor      = (m_addr[k] >> (AW + 2)) != 0;
        idx      = int'(m_addr[k][AW+1:2]);
        e_err[k] = oor;
        if (!m_wr[k]) begin
          e_rdata[k] = oor ? 32'd0 : m_mem[k][idx];
        end else if (!oor) begin
          for (int i = 0; i < 4; i++)
            if (m_be[k][i]) m_mem[k][idx][8*i +: 8] = m_wdata[k][8*i +: 8];
        end
      end
    end
    if (reset) started = 1'b1;
  end

  always @(negedge clock) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("busy%0d", k), 32'(busy[k]), 32'(e_busy[k]));
        check($sformatf("done%0d", k), 32'(done[k]), 32'(e_done[k]));
        check($sformatf("err%0d", k), 32'(err[k]), 32'(e_err[k]));
        check($sformatf("rdata%0d", k), rdata[k], e_rdata[k]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge with instance k idle; returns at the negedge after done.
  task automatic issue(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, output logic [31:0] rd, output logic er,
                       output int cyc);
    req[k] = 1'b1; wr[k] = w; addr[k] = a; wdata[k] = d; byte_en[k] = b;
    @(negedge clock);
    req[k] = 1'b0;
    cyc = 1;
    while (!done[k] && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
    check("done_seen", 32'(done[k]), 32'd1);
    rd = rdata[k];
    er = err[k];
    @(negedge clock);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] rd;
  logic        er;
  int          cyc;

  initial begin
    reset = 1'b1; req = '0; wr = '0; addr = '0; wdata = '0; byte_en = '0;
    @(negedge clock);
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      check("reset_busy", 32'(busy[k]), 32'd0);
      check("reset_done", 32'(done[k]), 32'd0);
      check("reset_err", 32'(err[k]), 32'd0);
      check("reset_rdata", rdata[k], 32'd0);
    end
    reset = 1'b0;

    // Give every word a known value in both RAMs.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 256; i++)
        issue(k, 1'b1, 32'(i) << 2, $urandom, 4'hF, rd, er, cyc);

    // Full write then read-back, with latency pinned.
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, cyc);
    check("t1_done_cycle", 32'(cyc), 32'd3);
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, cyc);
    check("t1_rdata", rd, 32'hDEADBEEF);

    // Single-lane write.
    issue(0, 1'b1, 32'h10, 32'h0000AB00, 4'b0010, rd, er, cyc);
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, cyc);
    check("t2_rdata", rd, 32'hDEADABEF);
    check("t2_err", 32'(er), 32'd0);

    // Out-of-range read and write.
    issue(0, 1'b1, 32'h0, 32'hA5A55A5A, 4'hF, rd, er, cyc);
    issue(0, 1'b0, 32'h400, 32'h0, 4'h0, rd, er, cyc);
    check("t3_oor_err", 32'(er), 32'd1);
    check("t3_oor_rdata", rd, 32'd0);
    issue(0, 1'b1, 32'h400, 32'h12345678, 4'hF, rd, er, cyc);
    check("t3_oor_wr_err", 32'(er), 32'd1);
    issue(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, cyc);
    check("t3_word0", rd, 32'hA5A55A5A);

    // Requests while busy are dropped.
    issue(0, 1'b1, 32'h20, 32'h0BADF00D, 4'hF, rd, er, cyc);
    req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h20;
    @(negedge clock);
    wr[0] = 1'b1; wdata[0] = 32'h11111111; byte_en[0] = 4'hF;
    repeat (2) @(negedge clock);
    check("t4_done", 32'(done[0]), 32'd1);
    check("t4_rdata", rdata[0], 32'h0BADF00D);
    @(negedge clock);
    req[0] = 1'b0;
    @(negedge clock);
    issue(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, cyc);
    check("t4_readback", rd, 32'h0BADF00D);

    // Reset during WAIT discards the write.
    issue(0, 1'b1, 32'h30, 32'h13579BDF, 4'hF, rd, er, cyc);
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h30; wdata[0] = 32'hCAFEF00D; byte_en[0] = 4'hF;
    @(negedge clock);
    req[0] = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("t5_busy", 32'(busy[0]), 32'd0);
    check("t5_done", 32'(done[0]), 32'd0);
    repeat (4) @(negedge clock);
    issue(0, 1'b0, 32'h30, 32'h0, 4'h0, rd, er, cyc);
    check("t5_readback", rd, 32'h13579BDF);

    // Zero-latency instance: done next cycle, held req re-accepted after done.
    issue(1, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, cyc);
    check("t6_done_cycle", 32'(cyc), 32'd1);
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h40;
    @(negedge clock);
    check("t6_c1_done", 32'(done[1]), 32'd1);
    @(negedge clock);
    check("t6_c2_busy", 32'(busy[1]), 32'd0);
    @(negedge clock);
    check("t6_c3_done", 32'(done[1]), 32'd1);
    req[1] = 1'b0;
    @(negedge clock);

    // Random traffic: inputs churn every cycle, occasional resets.
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 400; n++) begin
        req[k]     = ($urandom_range(0, 2) == 0);
        wr[k]      = 1'($urandom);
        addr[k]    = ($urandom_range(0, 9) == 0) ? $urandom
                                                  : {22'd0, 8'($urandom), 2'($urandom)};
        wdata[k]   = $urandom;
        byte_en[k] = 4'($urandom);
        reset      = ($urandom_range(0, 99) == 0);
        @(negedge clock);
      end
      req[k] = 1'b0;
      reset  = 1'b0;
      repeat (5) @(negedge clock);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
